dcache_assoc_control: RTL and testbench
=======================================

Name: dcache_assoc_control

Overview:
- Control FSM for a parametrised N-way set-associative, write-back, write-allocate data cache.
- Consumes per-way hit/valid/dirty vectors from the cache datapath.
- Drives way selection, datapath write strobes and the physical-memory handshake.
- Holds per-set tree pseudo-LRU state and picks victims from it.
- Sits between the CPU-side memory port and physical memory, alongside the cache datapath (tag/data/valid/dirty arrays).

Parameters:
- NUM_WAYS, 4, associativity; power of two, at least 2.
- NUM_SETS, 8, number of sets; power of two.
- SET_BITS, $clog2(NUM_SETS), set-index width (derived).
- WAY_BITS, $clog2(NUM_WAYS), way-index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_set  in  SET_BITS  set index of the request, stable while the request is held.
- mem_resp  out  1  request complete.
- way_hit  in  NUM_WAYS  per-way tag match AND valid.
- way_valid  in  NUM_WAYS  per-way valid bit of the indexed set.
- way_dirty  in  NUM_WAYS  per-way dirty bit of the indexed set.
- pmem_read  out  1  physical memory read.
- pmem_write  out  1  physical memory write.
- pmem_resp  in  1  physical memory done.
- pmem_address_sel  out  1  1 = victim tag address (writeback), 0 = CPU address.
- read_way  out  WAY_BITS  data-out / writeback mux select.
- write_way  out  NUM_WAYS  one-hot array write strobe; qualified by write_enable.
- write_enable  out  1  array write this cycle.
- datain_mux_sel  out  1  1 = CPU write data merge, 0 = pmem line.
- valid_in  out  1  valid bit written.
- dirty_in  out  1  dirty bit written.
- cache_allocate  out  1  tag load from CPU address.

Behaviour:
- States: IDLE, EVICT, ALLOCATE.
- Reset: state=IDLE, all PLRU bits=0, victim register=0.
  - All outputs 0, except read_way=0 (combinational in IDLE with no request).
- IDLE, hit (any way_hit bit set; hit way h = lowest set index):
  - mem_resp=1 in the same cycle; read_way=h.
  - Read: dirty_in=way_dirty[h], write_enable=0.
  - Write: write_enable=1, write_way=onehot(h), datain_mux_sel=1, valid_in=1, dirty_in=1.
  - PLRU[mem_set] updated at the clock edge ending the mem_resp cycle.
  - Stay in IDLE.
- IDLE, request with no hit:
  - Victim = lowest-index way with way_valid=0; if all ways are valid, the PLRU victim.
  - Victim registered into victim_q.
  - Next state is EVICT if way_valid[victim] && way_dirty[victim], else ALLOCATE.
  - mem_resp=0.
- If mem_read and mem_write are both set: treat as a read.
- EVICT:
  - pmem_write=1, pmem_address_sel=1, read_way=victim_q.
  - Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, read_way=victim_q.
  - On pmem_resp, same cycle: write_enable=1, write_way=onehot(victim_q), cache_allocate=1, valid_in=1, dirty_in=0, datain_mux_sel=0; then go to IDLE.
  - PLRU is not updated on allocate. The hit that follows in IDLE, one cycle later, updates it.
- Miss latency, clean: 1 IDLE cycle + pmem latency + 1 IDLE hit cycle. Dirty misses add the writeback.
- Tree PLRU: NUM_WAYS-1 bits per set, heap-ordered, node 0 is root; children of node i are 2i+1 and 2i+2.
  - Victim walk: bit=0 goes left, bit=1 goes right.
  - Access to way w: every node on w's path is set to point away from w.
- way_hit with more than one bit set: illegal; simulation assertion; lowest index wins.
- Request dropped before mem_resp: illegal; assertion.
- pmem_resp outside EVICT/ALLOCATE: ignored.
- rst mid-transaction: state returns to IDLE asynchronously; pmem_read/pmem_write deassert immediately; PLRU cleared. The CPU must reissue.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, EVICT, ALLOCATE);
  - way-index/one-hot conversion functions;
  - PLRU node-count constant.
- Sub-module plru_tree (NUM_WAYS, NUM_SETS):
  - per-set bit storage with asynchronous reset;
  - combinational victim output for a read-set index;
  - update port (valid, set, way).

Test Plan (NUM_WAYS=4, NUM_SETS=8):
- After rst, read with way_hit=0100, set 3 -> mem_resp=1 in the same cycle, read_way=2, no pmem activity. PLRU set 3 = {root=0, n1=0, n2=1}.
- From reset, read hit way 0 on set 5, then a miss on set 5 with way_valid=1111, way_dirty=0000 -> victim way 2. ALLOCATE asserts pmem_read; on pmem_resp, write_way=0100 with cache_allocate=1; next cycle hit (way_hit=0100) gives mem_resp.
- Write miss, way_valid=1111, way_dirty=0001, PLRU victim 0 -> EVICT: pmem_write=1, pmem_address_sel=1 for 5 cycles until pmem_resp. Then ALLOCATE, then IDLE write hit: write_enable=1, dirty_in=1, datain_mux_sel=1.
- Miss with way_valid=1101 and dirty way 0 -> invalid way 1 chosen, no EVICT, straight to ALLOCATE.
- rst asserted mid-EVICT, between clock edges -> pmem_write drops before the next edge, state=IDLE, all PLRU bits read 0.
- Hit ways 0, 1, 2, 3 in turn on set 0 -> victim returns to way 0; lowest-index-hit rule covered with way_hit=0110 -> read_way=1, assertion fires.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative data cache controller.
// Helper functions work on a fixed maximum width; callers cast to their own way count.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVICT,
        ALLOCATE
    } state_t;

    localparam int unsigned MAX_WAYS = 32;

    // A binary tree over N leaves has N-1 internal nodes, one PLRU bit each.
    function automatic int unsigned plru_nodes(input int unsigned ways);
        return ways - 1;
    endfunction

    function automatic logic [MAX_WAYS-1:0] to_onehot(input int unsigned idx);
        return MAX_WAYS'(1) << idx;
    endfunction

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic int unsigned lowest_set(input logic [MAX_WAYS-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: heap-ordered node bits, combinational victim walk,
// and a single update port that points every node on an accessed way's path away from it.
module plru_tree
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    parameter int SET_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] read_set,
    output logic [WAY_BITS-1:0] victim,
    input  logic                update_valid,
    input  logic [SET_BITS-1:0] update_set,
    input  logic [WAY_BITS-1:0] update_way
);

    localparam int unsigned NODES = plru_nodes(NUM_WAYS);

    logic [NODES-1:0] bits_q [NUM_SETS];
    logic [NODES-1:0] read_bits;
    logic [NODES-1:0] next_bits;

    // Walk from the root: a 0 bit descends left (2i+1), a 1 bit descends right (2i+2).
    always_comb begin
        int unsigned node;
        read_bits = bits_q[read_set];
        node      = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            node = 2 * node + 1 + 32'(1'(read_bits >> node));
        end
        victim = WAY_BITS'(node - NODES);
    end

    // Each path bit of the accessed way, MSB first, picks the child; the node is set to the other one.
    always_comb begin
        int unsigned node;
        logic        dir;
        // NOTE: every variable gets a value before any branch so no latch can be inferred.
        next_bits = bits_q[update_set];
        node      = 0;
        dir       = 1'b0;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir       = 1'(update_way >> (WAY_BITS - 1 - l));
            next_bits = (next_bits & ~(NODES'(1) << node)) | (NODES'(!dir) << node);
            node      = 2 * node + 1 + 32'(dir);
        end
    end

    // NOTE: the PLRU storage is cleared by reset because victim choice after reset must be deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) bits_q[s] <= '0;
        end else if (update_valid) begin
            bits_q[update_set] <= next_bits;
        end
    end

endmodule

// File: rtl/dcache_assoc_control.sv
// Control FSM for an N-way write-back, write-allocate data cache: hit handling, victim
// selection, dirty writeback and line fill, with tree-PLRU replacement per set.
module dcache_assoc_control
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    parameter int SET_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [SET_BITS-1:0] mem_set,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] way_hit,
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [NUM_WAYS-1:0] way_dirty,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp,
    output logic                pmem_address_sel,
    output logic [WAY_BITS-1:0] read_way,
    output logic [NUM_WAYS-1:0] write_way,
    output logic                write_enable,
    output logic                datain_mux_sel,
    output logic                valid_in,
    output logic                dirty_in,
    output logic                cache_allocate
);

    state_t              state_q;
    logic [WAY_BITS-1:0] victim_q;

    logic                request;
    logic                is_write;
    logic                hit;
    logic [WAY_BITS-1:0] hit_idx;
    logic [WAY_BITS-1:0] plru_victim;
    logic [WAY_BITS-1:0] victim_sel;
    logic                victim_dirty;
    logic                plru_update;

    assign request  = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;   // simultaneous read and write is served as a read
    assign hit      = |way_hit;
    assign hit_idx  = WAY_BITS'(lowest_set(MAX_WAYS'(way_hit)));

    // An empty way is always preferred over displacing a live line.
    assign victim_sel   = (&way_valid) ? plru_victim
                                       : WAY_BITS'(lowest_set(MAX_WAYS'(~way_valid)));
    assign victim_dirty = way_valid[victim_sel] & way_dirty[victim_sel];

    plru_tree #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS),
        .SET_BITS (SET_BITS),
        .WAY_BITS (WAY_BITS)
    ) u_plru (
        .clk          (clk),
        .rst          (rst),
        .read_set     (mem_set),
        .victim       (plru_victim),
        .update_valid (plru_update),
        .update_set   (mem_set),
        .update_way   (hit_idx)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request && !hit) begin
                        victim_q <= victim_sel;
                        state_q  <= victim_dirty ? EVICT : ALLOCATE;
                    end
                end
                EVICT:    if (pmem_resp) state_q <= ALLOCATE;
                ALLOCATE: if (pmem_resp) state_q <= IDLE;
                default:  state_q <= IDLE;
            endcase
        end
    end

    // Outputs depend on the current request so a hit completes in the cycle it is presented.
    always_comb begin
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_address_sel = 1'b0;
        read_way         = '0;
        write_way        = '0;
        write_enable     = 1'b0;
        datain_mux_sel   = 1'b0;
        valid_in         = 1'b0;
        dirty_in         = 1'b0;
        cache_allocate   = 1'b0;
        plru_update      = 1'b0;
        case (state_q)
            IDLE: begin
                read_way = hit_idx;
                if (request && hit) begin
                    mem_resp    = 1'b1;
                    plru_update = 1'b1;
                    if (is_write) begin
                        write_enable   = 1'b1;
                        write_way      = NUM_WAYS'(to_onehot(32'(hit_idx)));
                        datain_mux_sel = 1'b1;
                        valid_in       = 1'b1;
                        dirty_in       = 1'b1;
                    end else begin
                        dirty_in = way_dirty[hit_idx];
                    end
                end
            end
            EVICT: begin
                pmem_write       = 1'b1;
                pmem_address_sel = 1'b1;
                read_way         = victim_q;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                read_way  = victim_q;
                // The fill lands clean; the replayed hit in IDLE applies any CPU write.
                if (pmem_resp) begin
                    write_enable   = 1'b1;
                    write_way      = NUM_WAYS'(to_onehot(32'(victim_q)));
                    cache_allocate = 1'b1;
                    valid_in       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    multi_hit_a: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE && request) |-> $onehot0(way_hit))
        else $warning("dcache_assoc_control: several way_hit bits set, lowest index used");

    request_held_a: assert property (@(posedge clk) disable iff (rst)
        (state_q != IDLE) |-> request)
        else $error("dcache_assoc_control: request dropped before mem_resp");

endmodule

// File: tb/tb_dcache_assoc_control.sv
// Randomised and directed bench for dcache_assoc_control; expected values come from a
// recency-stamp model of tree PLRU and the cache's documented hit/miss/evict/fill rules.
module tb_dcache_assoc_control;

    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 8;
    localparam int SET_BITS = 3;
    localparam int WAY_BITS = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                mem_read = 1'b0;
    logic                mem_write = 1'b0;
    logic [SET_BITS-1:0] mem_set = '0;
    logic                mem_resp;
    logic [NUM_WAYS-1:0] way_hit = '0;
    logic [NUM_WAYS-1:0] way_valid = '0;
    logic [NUM_WAYS-1:0] way_dirty = '0;
    logic                pmem_read;
    logic                pmem_write;
    logic                pmem_resp = 1'b0;
    logic                pmem_address_sel;
    logic [WAY_BITS-1:0] read_way;
    logic [NUM_WAYS-1:0] write_way;
    logic                write_enable;
    logic                datain_mux_sel;
    logic                valid_in;
    logic                dirty_in;
    logic                cache_allocate;

    always #5 clk = ~clk;

    dcache_assoc_control #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_set          (mem_set),
        .mem_resp         (mem_resp),
        .way_hit          (way_hit),
        .way_valid        (way_valid),
        .way_dirty        (way_dirty),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_resp        (pmem_resp),
        .pmem_address_sel (pmem_address_sel),
        .read_way         (read_way),
        .write_way        (write_way),
        .write_enable     (write_enable),
        .datain_mux_sel   (datain_mux_sel),
        .valid_in         (valid_in),
        .dirty_in         (dirty_in),
        .cache_allocate   (cache_allocate)
    );

    typedef struct packed {
        logic                mem_resp;
        logic                pmem_read;
        logic                pmem_write;
        logic                pmem_address_sel;
        logic [WAY_BITS-1:0] read_way;
        logic [NUM_WAYS-1:0] write_way;
        logic                write_enable;
        logic                datain_mux_sel;
        logic                valid_in;
        logic                dirty_in;
        logic                cache_allocate;
    } outs_t;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: last-access time per (set, way); 0 means never touched since reset.
    int unsigned stamp [NUM_SETS][NUM_WAYS];
    int unsigned now_t = 0;

    function automatic outs_t observed();
        outs_t o;
        o.mem_resp         = mem_resp;
        o.pmem_read        = pmem_read;
        o.pmem_write       = pmem_write;
        o.pmem_address_sel = pmem_address_sel;
        o.read_way         = read_way;
        o.write_way        = write_way;
        o.write_enable     = write_enable;
        o.datain_mux_sel   = datain_mux_sel;
        o.valid_in         = valid_in;
        o.dirty_in         = dirty_in;
        o.cache_allocate   = cache_allocate;
        return o;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) stamp[s][w] = 0;
    endfunction

    function automatic void model_touch(input int set, input int way);
        now_t++;
        stamp[set][way] = now_t;
    endfunction

    // Tree PLRU as recency: in each half-range, steer away from the half holding the
    // most recent access; with no access in the range, take the left half.
    function automatic int model_victim(input int set);
        int lo = 0;
        int n  = NUM_WAYS;
        while (n > 1) begin
            int unsigned tl = 0;
            int unsigned tr = 0;
            int half = n / 2;
            for (int i = lo; i < lo + half; i++) if (stamp[set][i] > tl) tl = stamp[set][i];
            for (int i = lo + half; i < lo + n; i++) if (stamp[set][i] > tr) tr = stamp[set][i];
            if (tl > tr) lo = lo + half;
            n = half;
        end
        return lo;
    endfunction

    function automatic int lowest(input logic [NUM_WAYS-1:0] v);
        for (int i = 0; i < NUM_WAYS; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; way_hit = '0; pmem_resp = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete CPU transaction: hit, or miss with optional writeback, fill and replayed hit.
    task automatic run_access(input int set, input bit wr, input bit both,
                              input logic [NUM_WAYS-1:0] hit_vec, input logic [NUM_WAYS-1:0] valid,
                              input logic [NUM_WAYS-1:0] dirty, input int ev_lat, input int al_lat,
                              input bit idle_resp, input string name);
        outs_t exp;
        outs_t got;
        int    v;
        bit    wr_eff;
        bit    ev;
        logic [NUM_WAYS-1:0] vmask;
        wr_eff = wr && !both;
        @(posedge clk); #1;
        mem_set = SET_BITS'(set); mem_read = !wr || both; mem_write = wr;
        way_hit = hit_vec; way_valid = valid; way_dirty = dirty; pmem_resp = idle_resp;
        #1;
        if (hit_vec != '0) begin
            v = lowest(hit_vec);
        end else begin
            v = (&valid) ? model_victim(set) : lowest(~valid);
            ev = valid[v] && dirty[v];
            exp = '0;
            tests_run++; got = observed();
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL %s/idle_miss: got %h expected %h", name, got, exp);
            end
            if (ev) begin
                for (int c = 0; c < ev_lat; c++) begin
                    @(posedge clk); #1; pmem_resp = (c == ev_lat - 1); #1;
                    exp = '0; exp.pmem_write = 1'b1; exp.pmem_address_sel = 1'b1;
                    exp.read_way = WAY_BITS'(v);
                    tests_run++; got = observed();
                    if (got !== exp) begin
                        tests_failed++;
                        $display("FAIL %s/evict cyc%0d: got %h expected %h", name, c, got, exp);
                    end
                end
            end
            for (int c = 0; c < al_lat; c++) begin
                @(posedge clk); #1; pmem_resp = (c == al_lat - 1); #1;
                exp = '0; exp.pmem_read = 1'b1; exp.read_way = WAY_BITS'(v);
                if (c == al_lat - 1) begin
                    exp.write_enable = 1'b1; exp.write_way = NUM_WAYS'(1 << v);
                    exp.cache_allocate = 1'b1; exp.valid_in = 1'b1;
                end
                tests_run++; got = observed();
                if (got !== exp) begin
                    tests_failed++;
                    $display("FAIL %s/alloc cyc%0d: got %h expected %h", name, c, got, exp);
                end
            end
            @(posedge clk); #1;
            vmask = NUM_WAYS'(1 << v);
            pmem_resp = 1'b0; way_hit = vmask; way_valid = valid | vmask; way_dirty = dirty & ~vmask;
            #1;
        end
        exp = '0; exp.mem_resp = 1'b1; exp.read_way = WAY_BITS'(v);
        if (wr_eff) begin
            exp.write_enable = 1'b1; exp.write_way = NUM_WAYS'(1 << v);
            exp.datain_mux_sel = 1'b1; exp.valid_in = 1'b1; exp.dirty_in = 1'b1;
        end else begin
            exp.dirty_in = way_dirty[v];
        end
        tests_run++; got = observed();
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s/hit: got %h expected %h", name, got, exp);
        end
        model_touch(set, v);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; way_hit = '0; pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        outs_t got;
        #3;
        tests_run++; got = observed();
        if (got !== outs_t'(0)) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_hit();
        run_access(3, 0, 0, 4'b0100, 4'b1111, 4'b0000, 1, 1, 0, "read_hit_set3");
        tests_run++;
        if (dut.u_plru.bits_q[3] !== 3'b100) begin
            tests_failed++;
            $display("FAIL plru_set3: got %b expected 100", dut.u_plru.bits_q[3]);
        end
    endtask

    task automatic test_clean_miss();
        do_reset();
        run_access(5, 0, 0, 4'b0001, 4'b1111, 4'b0000, 1, 1, 0, "hit_w0_set5");
        tests_run++;
        if (model_victim(5) != 2) begin
            tests_failed++;
            $display("FAIL model_victim_set5: got %0d expected 2", model_victim(5));
        end
        run_access(5, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1, 3, 0, "clean_miss_set5");
    endtask

    task automatic test_dirty_write_miss();
        do_reset();
        run_access(1, 1, 0, 4'b0000, 4'b1111, 4'b0001, 5, 2, 0, "dirty_write_miss");
    endtask

    task automatic test_invalid_way();
        run_access(2, 0, 0, 4'b0000, 4'b1101, 4'b0001, 1, 2, 0, "invalid_way1");
    endtask

    task automatic test_reset_mid_evict();
        outs_t got;
        do_reset();
        run_access(4, 0, 0, 4'b0001, 4'b1111, 4'b0000, 1, 1, 0, "pre_evict_hit");
        @(posedge clk); #1;
        mem_set = 3'd4; mem_read = 1'b1; way_hit = '0; way_valid = 4'b1111; way_dirty = 4'b1111;
        @(posedge clk); #1;
        tests_run++;
        if (pmem_write !== 1'b1) begin
            tests_failed++;
            $display("FAIL evict_entered: pmem_write got %b expected 1", pmem_write);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++; got = observed();
        if (got !== outs_t'(0)) begin
            tests_failed++;
            $display("FAIL async_reset_outputs: got %h expected 0", got);
        end
        for (int s = 0; s < NUM_SETS; s++) begin
            tests_run++;
            if (dut.u_plru.bits_q[s] !== 3'b000) begin
                tests_failed++;
                $display("FAIL plru_cleared set%0d: got %b expected 000", s, dut.u_plru.bits_q[s]);
            end
        end
        mem_read = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        run_access(4, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1, 1, 0, "post_reset_miss");
    endtask

    task automatic test_plru_sequence();
        do_reset();
        for (int w = 0; w < NUM_WAYS; w++)
            run_access(0, 0, 0, NUM_WAYS'(1 << w), 4'b1111, 4'b0000, 1, 1, 0, "seq_hit");
        tests_run++;
        if (model_victim(0) != 0) begin
            tests_failed++;
            $display("FAIL model_victim_seq: got %0d expected 0", model_victim(0));
        end
        run_access(0, 0, 0, 4'b0000, 4'b1111, 4'b0000, 1, 2, 0, "seq_victim_miss");
    endtask

    task automatic test_corner_inputs();
        run_access(6, 0, 0, 4'b0110, 4'b1111, 4'b0010, 1, 1, 0, "multi_hit");
        run_access(6, 1, 1, 4'b1000, 4'b1111, 4'b0000, 1, 1, 0, "read_and_write");
        run_access(7, 1, 0, 4'b0010, 4'b1111, 4'b0000, 1, 1, 1, "idle_pmem_resp");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int set;
            int h;
            logic [NUM_WAYS-1:0] hv;
            logic [NUM_WAYS-1:0] vv;
            logic [NUM_WAYS-1:0] dv;
            set = int'($urandom_range(NUM_SETS - 1));
            h   = int'($urandom_range(NUM_WAYS - 1));
            vv  = NUM_WAYS'($urandom);
            dv  = NUM_WAYS'($urandom);
            if ($urandom_range(2) == 0) begin
                hv = '0;
                if ($urandom_range(1) == 0) vv = '1;
            end else begin
                hv = NUM_WAYS'(1 << h);
                vv = vv | hv;
            end
            run_access(set, bit'($urandom_range(1)), ($urandom_range(7) == 0), hv, vv, dv,
                       int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                       bit'($urandom_range(1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_write_miss();
        test_invalid_way();
        test_reset_mid_evict();
        test_plru_sequence();
        test_corner_inputs();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
